// File: rtl/acc_bank_pkg.sv
// Shared types and helpers for the output accumulator bank.
// Saturating add and reduce-width sizing used by bank and reduce tree.
package acc_bank_pkg;

  typedef enum logic {
    ACC,
    DRAIN
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_res_t;

  function automatic int red_bw(input int acc_bw, input int lanes);
    return acc_bw + $clog2(lanes);
  endfunction

  // Operands arrive sign-extended to 64 bits; w must be below 63.
  function automatic sat_res_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sat_res_t           r;
    s     = a + b;
    mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn    = -mx - 64'sd1;
    r.sat = (s > mx) || (s < mn);
    r.val = (s > mx) ? mx : (s < mn) ? mn : s;
    return r;
  endfunction

endpackage

// File: rtl/accumulator_bank_reduce.sv
// Combinational cross-lane signed sum with saturation to ACC_BW.
// Grows to ACC_BW+log2(lanes) internally so the sum itself never wraps.
module acc_reduce_tree
  import acc_bank_pkg::*;
#(
  parameter int ARR_SIZE = 4,
  parameter int ACC_BW   = 32
) (
  input  logic [ARR_SIZE*ACC_BW-1:0] lanes,
  output logic [ACC_BW-1:0]          sum,
  output logic                       sat
);

  localparam int RBW = red_bw(ACC_BW, ARR_SIZE);

  localparam logic signed [RBW-1:0] MAXV =
    {{(RBW-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
  localparam logic signed [RBW-1:0] MINV =
    {{(RBW-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};

  logic signed [RBW-1:0] total;

  always_comb begin
    total = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      total = total +
        RBW'(signed'(lanes[i*ACC_BW +: ACC_BW]));
    end
  end

  always_comb begin
    sat = (total > MAXV) || (total < MINV);
    sum = total[ACC_BW-1:0];
    if (total > MAXV) sum = MAXV[ACC_BW-1:0];
    if (total < MINV) sum = MINV[ACC_BW-1:0];
  end

endmodule

// File: rtl/accumulator_bank.sv
// Multi-row saturating output accumulator for the systolic array.
// Collects K-tile partial sums per row and drains rows over valid/ready.
module accumulator_bank
  import acc_bank_pkg::*;
#(
  parameter int ARR_SIZE    = 4,
  parameter int VERTICAL_BW = 32,
  parameter int ACC_BW      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_BW     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
  input  logic [ADDR_BW-1:0]          in_row,
  input  logic                        in_first,
  input  logic                        drain_start,
  input  logic [ADDR_BW:0]            drain_rows,
  input  logic                        drain_reduce,
  input  logic                        drain_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ARR_SIZE*ACC_BW-1:0]  out_data,
  output logic [ADDR_BW-1:0]          out_addr,
  output logic                        sat_flag,
  output logic                        busy
);

  typedef logic [ARR_SIZE*ACC_BW-1:0] row_t;

  row_t           mem [DEPTH];
  state_t         state, state_nxt;
  logic [ADDR_BW:0] cnt;
  logic [ADDR_BW:0] rows_clamped;
  logic           red_q, clr_q;
  logic           wr_en, drain_go, beat, last;
  row_t           wr_row, rd_row, red_row;
  logic           wr_sat;
  logic [ACC_BW-1:0] red_sum;
  logic           red_sat;

  assign in_ready = (state == ACC);
  assign busy     = (state == DRAIN);
  assign wr_en    = in_valid && in_ready &&
                    (32'(in_row) < 32'(DEPTH));
  assign drain_go = drain_start && (state == ACC) &&
                    (drain_rows != '0);
  assign rows_clamped =
    (drain_rows > (ADDR_BW+1)'(DEPTH)) ?
    (ADDR_BW+1)'(DEPTH) : drain_rows;
  assign beat = out_valid && out_ready;
  assign last = beat &&
    (({1'b0, out_addr} + (ADDR_BW+1)'(1)) == cnt);

  always_comb begin
    logic signed [63:0] ext;
    logic signed [63:0] cur;
    sat_res_t           r;
    wr_row = '0;
    wr_sat = 1'b0;
    for (int k = 0; k < ARR_SIZE; k++) begin
      ext = 64'(signed'(in_data[k*VERTICAL_BW +: VERTICAL_BW]));
      cur = 64'(signed'(mem[in_row][k*ACC_BW +: ACC_BW]));
      r   = sat_add(cur, ext, ACC_BW);
      if (in_first) begin
        wr_row[k*ACC_BW +: ACC_BW] = ext[ACC_BW-1:0];
      end else begin
        wr_row[k*ACC_BW +: ACC_BW] = r.val[ACC_BW-1:0];
        wr_sat = wr_sat | r.sat;
      end
    end
  end

  // Bank is frozen in DRAIN, so reading by out_addr holds data stable.
  assign rd_row = mem[out_addr];

  acc_reduce_tree #(
    .ARR_SIZE (ARR_SIZE),
    .ACC_BW   (ACC_BW)
  ) u_reduce (
    .lanes (rd_row),
    .sum   (red_sum),
    .sat   (red_sat)
  );

  always_comb begin
    red_row = '0;
    red_row[ACC_BW-1:0] = red_sum;
    out_data = '0;
    if (out_valid) out_data = red_q ? red_row : rd_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (drain_go) state_nxt = DRAIN;
      DRAIN:   if (last)     state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      cnt       <= '0;
      red_q     <= 1'b0;
      clr_q     <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[in_row] <= wr_row;
        if (wr_sat) sat_flag <= 1'b1;
      end
      if (drain_go) begin
        cnt       <= rows_clamped;
        red_q     <= drain_reduce;
        clr_q     <= drain_clear;
        out_valid <= 1'b1;
        out_addr  <= '0;
      end
      if (beat) begin
        if (red_q && red_sat) sat_flag <= 1'b1;
        if (last) begin
          out_valid <= 1'b0;
          if (clr_q) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sat_flag <= 1'b0;
          end
        end else begin
          out_addr <= out_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
Multi-row, multi-column output accumulator for the systolic array. It collects per-column partial sums from the bottom row of the array into a DEPTH-row bank of saturating accumulators, one row per output-matrix row, across several K-tiles. On command it drains rows to the output buffer over a valid/ready handshake, either per column or reduced across columns into a single lane. It sits between the array's vertical outputs and the output buffer and generalises the single-register column accumulator.

Parameters:
ARR_SIZE, 4, number of array columns (lanes)
VERTICAL_BW, 32, width of each signed column input
ACC_BW, 32, width of each signed accumulator (ACC_BW >= VERTICAL_BW)
DEPTH, 16, number of accumulator rows
ADDR_BW, $clog2(DEPTH), row address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  column partial sums present
in_ready  out  1  bank accepts input (high only in ACC state)
in_data  in  ARR_SIZE*VERTICAL_BW  lane k at [k*VERTICAL_BW +: VERTICAL_BW], signed
in_row  in  ADDR_BW  target accumulator row
in_first  in  1  1 = overwrite row (first K-tile), 0 = accumulate
drain_start  in  1  one-cycle drain command, sampled in ACC only
drain_rows  in  ADDR_BW+1  rows to drain, starting at row 0
drain_reduce  in  1  1 = sum all lanes into lane 0
drain_clear  in  1  1 = zero entire bank after last beat
out_valid  out  1  output beat valid
out_ready  in  1  output buffer accepts beat
out_data  out  ARR_SIZE*ACC_BW  drained row (lane layout as in_data)
out_addr  out  ADDR_BW  row index of current beat
sat_flag  out  1  sticky: any saturation since reset or clear
busy  out  1  high in DRAIN

Behaviour:
- Reset (rst=0, async): all accumulators 0; state ACC; out_valid=0; out_data=0; out_addr=0; sat_flag=0; busy=0; in_ready=1 after release.
- States: ACC, DRAIN.
- ACC: in_ready=1. Write happens on in_valid && in_ready. Each lane is sign-extended to ACC_BW. in_first=1 stores the value. in_first=0 adds it to the row with signed saturation to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1]. Saturation sets sat_flag. Write latency 1 cycle. in_row >= DEPTH: write dropped, no flag.
- drain_start in ACC with drain_rows=0: ignored. drain_rows > DEPTH clamps to DEPTH. Otherwise latch the count, reduce and clear mode, then go to DRAIN next cycle.
- in_valid and drain_start in the same cycle: the write commits first, and the drain sees the updated row.
- DRAIN: in_ready=0, busy=1. On the first DRAIN cycle, row 0 is loaded into the output register and out_valid=1, out_addr=0.
- Each out_valid && out_ready loads the next row in the same cycle, giving 1 beat/cycle throughput. out_data and out_addr stay stable while stalled.
- After the last beat is accepted: out_valid=0, return to ACC. If drain_clear, all rows are zeroed and sat_flag cleared on that same edge.
- Reduce mode: lane 0 = sum of all ARR_SIZE lanes computed at ACC_BW+$clog2(ARR_SIZE), saturated to ACC_BW (sets sat_flag). Lanes 1..ARR_SIZE-1 = 0.
- drain_start during DRAIN: ignored.
- Reset mid-drain aborts the drain; bank cleared per reset values.

Decomposition:
- Package acc_bank_pkg: state enum {ACC, DRAIN}; function sat_add(signed a, signed b, width); localparam for reduce-sum width.
- Sub-module acc_reduce_tree: combinational, parametrised by ARR_SIZE/ACC_BW. Signed adder tree over ARR_SIZE lanes plus final saturation; outputs sum and a sat bit.

Test Plan:
- Reset then in_first=1, in_row=2, lanes {1,2,3,4}; then in_first=0, lanes {10,20,30,40}; drain_rows=3 -> beats addr 0,1,2. Addr 2 data {11,22,33,44}; rows 0,1 = 0.
- Row 0 = 0x7FFFFFF0, accumulate 0x20 -> row 0 = 0x7FFFFFFF, sat_flag=1. Accumulate -0x40 into a 0x80000010 row -> 0x80000000.
- drain_reduce=1, row 0 lanes {5,-3,7,1} -> out_data lane0=10, lanes1-3=0. All lanes 0x7FFFFFFF -> lane0=0x7FFFFFFF, sat_flag=1.
- drain_rows=4 with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 beats, addr 0..3 in order, data stable while stalled. in_ready=0 until final accept.
- in_valid (row 0, accumulate 1) and drain_start in the same cycle -> row 0 beat shows the incremented value. drain_clear=1 -> next drain of 1 row returns 0, sat_flag=0.
- Assert rst=0 mid-drain after 2 of 5 beats -> out_valid=0 immediately, busy=0. After release, a 1-row drain returns zeros.
